credit_sched: RTL
=================

Name: credit_sched

Overview:
- Controller and arbiter that shares one credit counter among NUM_REQ requesters.
- Drives the counter's reinit, initial_value, incr and decr controls, and reads back its registered value.
- Grants credit requests round-robin, only when enough credits are available.
- Accepts credit returns on the incr path, clamps them to the configured maximum, and sequences (re)initialisation.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 4, counter value width
AMT_W, 2, width of request, return, incr and decr amounts

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_credits  in  WIDTH  credit pool size; loaded at init
cfg_load  in  1  pulse; re-initialise pool from cfg_credits
req_valid  in  NUM_REQ  per-requester request
req_amt  in  NUM_REQ*AMT_W  per-requester amount; slice i is [i*AMT_W +: AMT_W]
gnt  out  NUM_REQ  one-hot grant, at most one bit set
gnt_id  out  $clog2(NUM_REQ)  index of granted requester; 0 when none
ret_valid  in  1  credit return valid
ret_amt  in  AMT_W  credits returned
ret_ready  out  1  return accepted when ret_valid & ret_ready
ctr_value  in  WIDTH  counter's registered value
ctr_reinit  out  1  counter reinit
ctr_initial_value  out  WIDTH  counter initial value
ctr_incr_valid  out  1  counter incr enable
ctr_incr  out  AMT_W  counter incr amount
ctr_decr_valid  out  1  counter decr enable
ctr_decr  out  AMT_W  counter decr amount
ovf_sticky  out  1  a return was clamped since the last init
busy_init  out  1  high in INIT state

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- While rst is high, all outputs are forced to 0.
- Registers reset to: state=INIT, rr_ptr=0, max_q=0, ovf_sticky=0.
- States:
  - INIT: ctr_reinit=1; ctr_initial_value=cfg_credits; max_q<=cfg_credits; ovf_sticky<=0; gnt=0; ret_ready=0; incr_valid=decr_valid=0. Goes to RUN unconditionally after 1 cycle.
  - RUN: arbitration and returns active. cfg_load=1 goes to INIT next cycle.
  - A cfg_load arriving in the same cycle as a grant still honours that grant; INIT follows.
- cfg_load is ignored in INIT. rst mid-operation returns to INIT on the cycle after rst falls.
- Eligibility: requester i is eligible when req_valid[i] and req_amt[i] <= ctr_value (unsigned).
- Arbitration (RUN only, combinational, same cycle):
  - Scan i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first eligible requester wins.
  - gnt[w]=1, gnt_id=w, ctr_decr_valid=1, ctr_decr=req_amt[w].
  - req_amt=0 is granted with ctr_decr_valid=1 and ctr_decr=0.
- Round-robin pointer: on any grant, rr_ptr <= (w+1) mod NUM_REQ; with no grant, rr_ptr holds.
- Grant handshake: gnt is a single-cycle acknowledge; the requester must drop or change req_valid on the next cycle. A held req_valid is re-arbitrated as a new request.
- Returns: ret_ready=1 in RUN. When ret_valid & ret_ready, ctr_incr_valid=1.
- Clamp, with d = granted amount (0 if no grant) and s = ctr_value + ret_amt − d computed at WIDTH+1 bits:
  - if s > max_q: ctr_incr = ret_amt − (s − max_q), and ovf_sticky <= 1;
  - else ctr_incr = ret_amt.
- Simultaneous grant and return in the same cycle are both issued; the counter applies both at the next edge.
- Decisions use the registered ctr_value only. A return in cycle N enables grants from cycle N+1.
- The counter therefore never underflows and never exceeds max_q.

Optional Feature:
- Macro: CREDIT_SCHED_STRICT_RR_EN.
- Defined (head-of-line strict round-robin):
  - Only the first req_valid requester at or after rr_ptr is considered.
  - If its amount exceeds ctr_value, no grant is issued and rr_ptr holds.
  - Guarantees no starvation of large requests.
- Undefined: skip-ahead to the first eligible requester as specified above.

Test Plan:
All with NUM_REQ=4, WIDTH=4, AMT_W=2.
1. Reset then cfg_credits=5 → cycle 1 after rst falls: ctr_reinit=1, initial_value=5, busy_init=1; cycle 2: RUN, ret_ready=1.
2. ctr_value=5; req_valid=1111, all amounts=1, held 4 cycles with ctr_value tracking → gnt sequence 0001, 0010, 0100, 1000; decr=1 each cycle; final value 1.
3. ctr_value=1; req0 amt=2, req1 amt=1, rr_ptr=0 → gnt=0010 and decr=1. With CREDIT_SCHED_STRICT_RR_EN: gnt=0000 and rr_ptr stays 0.
4. ctr_value=4, max=5, ret_valid with ret_amt=3, no request → ctr_incr=1, ovf_sticky=1, next value 5.
5. ctr_value=3; req2 amt=2 granted while ret_amt=2 in the same cycle → decr=2, incr=2, value stays 3, ovf_sticky stays 0.
6. cfg_load=1 with cfg_credits=7 during RUN while req0 is granted → that grant is honoured; next cycle INIT with ret_ready=0 and gnt=0; ovf_sticky is cleared; counter reloads to 7.

Source files
------------

// File: rtl/credit_sched_if.sv
// Request/grant and credit-return signals between credit_sched (slave) and its requesters (master).
// Combinational grant/ready paths; no storage in the interface itself.
// Requesters hold req_valid until gnt; returns complete on ret_valid & ret_ready.
interface credit_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int AMT_W   = 2
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*AMT_W-1:0] req_amt;
  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_id;
  logic                     ret_valid;
  logic [AMT_W-1:0]         ret_amt;
  logic                     ret_ready;

  modport master (
    output req_valid, req_amt, ret_valid, ret_amt,
    input  gnt, gnt_id, ret_ready
  );

  modport slave (
    input  req_valid, req_amt, ret_valid, ret_amt,
    output gnt, gnt_id, ret_ready
  );
endinterface

// File: rtl/credit_sched.sv
// Round-robin credit arbiter driving a shared credit counter; CREDIT_SCHED_STRICT_RR_EN selects head-of-line RR.
// Latency: grant and clamped return issued combinationally in the cycle they are presented.
// Backpressure: grants only when credits suffice; ret_ready low during INIT and reset.
module credit_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int AMT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cfg_credits,
  input  logic             cfg_load,
  credit_sched_if.slave    bus,
  input  logic [WIDTH-1:0] ctr_value,
  output logic             ctr_reinit,
  output logic [WIDTH-1:0] ctr_initial_value,
  output logic             ctr_incr_valid,
  output logic [AMT_W-1:0] ctr_incr,
  output logic             ctr_decr_valid,
  output logic [AMT_W-1:0] ctr_decr,
  output logic             ovf_sticky,
  output logic             busy_init
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             ovf_q, ovf_d;

  logic             win_vld;
  logic [ID_W-1:0]  win_id;
  logic [AMT_W-1:0] win_amt;
  logic [ID_W:0]    idx;
  logic [ID_W-1:0]  cand;
  logic [AMT_W-1:0] cand_amt;
  logic             cand_elig;
  logic [WIDTH:0]   sum;
`ifdef CREDIT_SCHED_STRICT_RR_EN
  logic             head_seen;
`endif

  always_comb begin
    win_vld   = 1'b0;
    win_id    = '0;
    win_amt   = '0;
    idx       = '0;
    cand      = '0;
    cand_amt  = '0;
    cand_elig = 1'b0;
`ifdef CREDIT_SCHED_STRICT_RR_EN
    head_seen = 1'b0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      cand      = idx[ID_W-1:0];
      cand_amt  = bus.req_amt[cand*AMT_W +: AMT_W];
      cand_elig = bus.req_valid[cand] &&
                  ((WIDTH+AMT_W)'(cand_amt) <= (WIDTH+AMT_W)'(ctr_value));
`ifdef CREDIT_SCHED_STRICT_RR_EN
      // Only the oldest-in-turn requester may win; a too-large head blocks everyone.
      if (!head_seen && bus.req_valid[cand]) begin
        head_seen = 1'b1;
        if (cand_elig) begin
          win_vld = 1'b1;
          win_id  = cand;
          win_amt = cand_amt;
        end
      end
`else
      if (!win_vld && cand_elig) begin
        win_vld = 1'b1;
        win_id  = cand;
        win_amt = cand_amt;
      end
`endif
    end
  end

  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    max_d             = max_q;
    ovf_d             = ovf_q;
    bus.gnt           = '0;
    bus.gnt_id        = '0;
    bus.ret_ready     = 1'b0;
    ctr_reinit        = 1'b0;
    ctr_initial_value = '0;
    ctr_incr_valid    = 1'b0;
    ctr_incr          = '0;
    ctr_decr_valid    = 1'b0;
    ctr_decr          = '0;
    busy_init         = 1'b0;
    ovf_sticky        = ovf_q & ~rst;
    sum               = '0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          ctr_reinit        = 1'b1;
          ctr_initial_value = cfg_credits;
          max_d             = cfg_credits;
          ovf_d             = 1'b0;
          busy_init         = 1'b1;
          state_d           = ST_RUN;
        end
        default: begin
          bus.ret_ready = 1'b1;
          if (win_vld) begin
            bus.gnt[win_id] = 1'b1;
            bus.gnt_id      = win_id;
            ctr_decr_valid  = 1'b1;
            ctr_decr        = win_amt;
            rr_ptr_d        = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
          end
          // Post-update level accounts for this cycle's grant so the clamp is exact.
          sum = {1'b0, ctr_value} + (WIDTH+1)'(bus.ret_amt) - (WIDTH+1)'(ctr_decr);
          if (bus.ret_valid) begin
            ctr_incr_valid = 1'b1;
            if (sum > {1'b0, max_q}) begin
              ctr_incr = bus.ret_amt - AMT_W'(sum - {1'b0, max_q});
              ovf_d    = 1'b1;
            end else begin
              ctr_incr = bus.ret_amt;
            end
          end
          if (cfg_load) begin
            state_d = ST_INIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      rr_ptr_q <= '0;
      max_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      max_q    <= max_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule
